// File: rtl/button_debouncer.sv
// Per-channel push-button debouncer: 2-flop synchronizer, strobe-counted stability filter, registered edge pulses.
// Latency: 2 clk sync + STABLE_TICKS sample strobes to button_db; press/release pulses one clk after button_db moves.
module button_debouncer #(
    parameter int N_BUTTONS    = 5,
    parameter int STABLE_TICKS = 10,
    parameter int CNT_W        = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic [N_BUTTONS-1:0] button_in,
    output logic [N_BUTTONS-1:0] button_db,
    output logic [N_BUTTONS-1:0] button_press,
    output logic [N_BUTTONS-1:0] button_release,
    output logic                 any_press
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_TICKS - 1);

    logic [N_BUTTONS-1:0] sync1_q, sync2_q;
    logic [N_BUTTONS-1:0] db_q, db_d;
    logic [N_BUTTONS-1:0] prev_q;
    logic [N_BUTTONS-1:0] press_q, release_q;
    logic [CNT_W-1:0]     cnt_q [N_BUTTONS];
    logic [CNT_W-1:0]     cnt_d [N_BUTTONS];

    // Counter only advances while the synchronized level disagrees; it is
    // cleared when it reaches LAST_CNT, so it can never wrap.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < N_BUTTONS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sample_en) begin
                if (sync2_q[i] != db_q[i]) begin
                    if (cnt_q[i] == LAST_CNT) begin
                        db_d[i]  = sync2_q[i];
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            prev_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= button_in;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            prev_q    <= db_q;
            press_q   <= db_q & ~prev_q;
            release_q <= ~db_q & prev_q;
            for (int i = 0; i < N_BUTTONS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign button_db      = db_q;
    assign button_press   = press_q;
    assign button_release = release_q;
    assign any_press      = |press_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (defaults: 5 channels, STABLE_TICKS=10).
module tb_button_debouncer;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_en;
    logic [4:0] button_in;
    logic [4:0] button_db;
    logic [4:0] button_press;
    logic [4:0] button_release;
    logic       any_press;

    int checks = 0;
    int errors = 0;

    int press_cnt [5];
    int rel_cnt   [5];
    int any_cnt   = 0;
    int both_err  = 0;
    int any_err   = 0;

    button_debouncer dut (
        .clk           (clk),
        .reset         (reset),
        .sample_en     (sample_en),
        .button_in     (button_in),
        .button_db     (button_db),
        .button_press  (button_press),
        .button_release(button_release),
        .any_press     (any_press)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int b = 0; b < 5; b++) begin
            if (button_press[b])   press_cnt[b]++;
            if (button_release[b]) rel_cnt[b]++;
        end
        if (any_press) any_cnt++;
        if ((button_press & button_release) != 5'b0) both_err++;
        if (any_press != (|button_press)) any_err++;
    end

    typedef struct {
        logic [4:0] in;
        int         strobes;
        logic [4:0] db;
        logic [4:0] press;
        logic [4:0] rel;
        int         any;
    } vec_t;

    vec_t vecs [16];

    int bp [5];
    int br [5];
    int ba;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic strobe(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (4) @(negedge clk);
            sample_en = 1'b1;
            @(negedge clk);
            sample_en = 1'b0;
        end
    endtask

    task automatic snap();
        for (int b = 0; b < 5; b++) begin
            bp[b] = press_cnt[b];
            br[b] = rel_cnt[b];
        end
        ba = any_cnt;
    endtask

    task automatic chk_pulses(input string name, input logic [4:0] exp_p,
                              input logic [4:0] exp_r, input int exp_any);
        for (int b = 0; b < 5; b++) begin
            chk($sformatf("%s press[%0d]", name, b), press_cnt[b] - bp[b], {31'b0, exp_p[b]});
            chk($sformatf("%s release[%0d]", name, b), rel_cnt[b] - br[b], {31'b0, exp_r[b]});
        end
        chk($sformatf("%s any_press", name), any_cnt - ba, exp_any);
    endtask

    initial begin
        // clean press/release on ch0, 9-vs-10 strobe boundary
        vecs[0]  = '{5'b00001,  9, 5'b00000, 5'b00000, 5'b00000, 0};
        vecs[1]  = '{5'b00001,  1, 5'b00001, 5'b00001, 5'b00000, 1};
        vecs[2]  = '{5'b00000,  9, 5'b00001, 5'b00000, 5'b00000, 0};
        vecs[3]  = '{5'b00000,  1, 5'b00000, 5'b00000, 5'b00001, 0};
        // glitch on ch4: 9 strobes never accepted, count restarts
        vecs[4]  = '{5'b10000,  9, 5'b00000, 5'b00000, 5'b00000, 0};
        vecs[5]  = '{5'b00000,  5, 5'b00000, 5'b00000, 5'b00000, 0};
        vecs[6]  = '{5'b10000,  9, 5'b00000, 5'b00000, 5'b00000, 0};
        vecs[7]  = '{5'b00000,  1, 5'b00000, 5'b00000, 5'b00000, 0};
        // bounce on ch2: high 3, low 1, high 12
        vecs[8]  = '{5'b00100,  3, 5'b00000, 5'b00000, 5'b00000, 0};
        vecs[9]  = '{5'b00000,  1, 5'b00000, 5'b00000, 5'b00000, 0};
        vecs[10] = '{5'b00100,  9, 5'b00000, 5'b00000, 5'b00000, 0};
        vecs[11] = '{5'b00100,  1, 5'b00100, 5'b00100, 5'b00000, 1};
        vecs[12] = '{5'b00100,  2, 5'b00100, 5'b00000, 5'b00000, 0};
        vecs[13] = '{5'b00000, 10, 5'b00000, 5'b00000, 5'b00100, 0};
        // simultaneous transitions on three channels
        vecs[14] = '{5'b10101, 10, 5'b10101, 5'b10101, 5'b00000, 1};
        vecs[15] = '{5'b00000, 10, 5'b00000, 5'b00000, 5'b10101, 0};

        reset     = 1'b1;
        sample_en = 1'b0;
        button_in = 5'b0;
        repeat (3) @(negedge clk);
        chk("reset db", button_db, 5'b0);
        chk("reset press", button_press, 5'b0);
        chk("reset release", button_release, 5'b0);
        chk("reset any", any_press, 1'b0);
        snap();
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk_pulses("post-reset", 5'b0, 5'b0, 0);

        for (int v = 0; v < 16; v++) begin
            snap();
            button_in = vecs[v].in;
            strobe(vecs[v].strobes);
            repeat (4) @(negedge clk);
            chk($sformatf("vec%0d db", v), button_db, vecs[v].db);
            chk_pulses($sformatf("vec%0d", v), vecs[v].press, vecs[v].rel, vecs[v].any);
        end

        // exact edge timing on ch3: db on the strobe edge, press one clk later
        button_in = 5'b01000;
        strobe(9);
        repeat (4) @(negedge clk);
        chk("lat db before 10th", button_db, 5'b0);
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        chk("lat db after 10th", button_db, 5'b01000);
        chk("lat press not yet", button_press, 5'b0);
        @(negedge clk);
        chk("lat press", button_press, 5'b01000);
        chk("lat any", any_press, 1'b1);
        @(negedge clk);
        chk("lat press gone", button_press, 5'b0);
        chk("lat any gone", any_press, 1'b0);
        button_in = 5'b0;
        strobe(10);
        repeat (4) @(negedge clk);
        chk("lat release db", button_db, 5'b0);

        // reset mid-count on ch1 discards the 6 pending strobes
        button_in = 5'b00010;
        strobe(6);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst db", button_db, 5'b0);
        chk("midrst press", button_press, 5'b0);
        chk("midrst release", button_release, 5'b0);
        chk("midrst any", any_press, 1'b0);
        snap();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_pulses("midrst deassert", 5'b0, 5'b0, 0);
        strobe(9);
        repeat (4) @(negedge clk);
        chk("midrst db after 9", button_db, 5'b0);
        strobe(1);
        repeat (4) @(negedge clk);
        chk("midrst db after 10", button_db, 5'b00010);
        chk_pulses("midrst press", 5'b00010, 5'b0, 1);
        button_in = 5'b0;
        strobe(10);
        repeat (4) @(negedge clk);
        chk("midrst release db", button_db, 5'b0);

        // no strobes: arbitrary input activity must not reach the outputs
        snap();
        repeat (10000) begin
            @(negedge clk);
            button_in = 5'($urandom);
        end
        button_in = 5'b0;
        repeat (4) @(negedge clk);
        chk("no-strobe db", button_db, 5'b0);
        chk_pulses("no-strobe", 5'b0, 5'b0, 0);

        chk("press&release overlap", both_err, 0);
        chk("any_press vs press", any_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
